// File: rtl/egress_ddr_reader_if.sv
// egress_ddr_reader_if: AXI4 read channels toward DDR plus the AXI4-Stream toward AMPER
interface egress_ddr_reader_if #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 512
);
    logic [ADDR_WIDTH-1:0]   m_axi_araddr;
    logic [7:0]              m_axi_arlen;
    logic [2:0]              m_axi_arsize;
    logic [1:0]              m_axi_arburst;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;
    logic [DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]              m_axi_rresp;
    logic                    m_axi_rlast;
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;
    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
    logic                    m_axis_tlast;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/egress_ddr_reader.sv
// egress_ddr_reader: drains framed packets from the DDR ring to AXI4-Stream; LEN_VOTE_EN selects majority-voted length
module egress_ddr_reader #(
    parameter int              ADDR_WIDTH     = 31,
    parameter int              DATA_WIDTH     = 512,
    parameter longint unsigned RING_BYTES     = 64'h8000_0000,
    parameter int              MIN_PKT_LENGTH = 59,
    parameter int              MAX_PKT_LENGTH = 1515
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] ddr_wr_ptr,
    output logic [ADDR_WIDTH-1:0] ddr_rd_ptr,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           err_cnt,
    egress_ddr_reader_if.master   bus
);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int LOG_B = $clog2(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] RING_MASK = ADDR_WIDTH'(RING_BYTES - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(BEAT_BYTES);
    localparam logic [47:0] FEP = 48'h1ead_feb5_ac0d;

    typedef enum logic [2:0] {IDLE, HDR_AR, HDR_R, HDR_OUT, BODY_AR, BODY_R} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, araddr_q, baddr_q;
    logic [7:0]              arlen_q;
    logic                    arvalid_q;
    logic [DATA_WIDTH-1:0]   hdr_q;
    logic [LOG_B-1:0]        tail_q;
    logic [15:0]             rem_q;
    logic [31:0]             pkt_q, err_q;

    logic [15:0]             hdr_len, hdr_beats;
    logic                    hdr_ok, r_hs;
    logic [ADDR_WIDTH-1:0]   next_beat;
    logic [BEAT_BYTES-1:0]   keep_last;

`ifdef LEN_VOTE_EN
    logic [15:0] len_a, len_b, len_c;
    assign len_a = bus.m_axi_rdata[15:0];
    assign len_b = bus.m_axi_rdata[31:16];
    assign len_c = bus.m_axi_rdata[47:32];
    assign hdr_len = (len_a & len_b) | (len_a & len_c) | (len_b & len_c);
`else
    assign hdr_len = bus.m_axi_rdata[15:0];
`endif

    assign hdr_beats = 16'((17'(hdr_len) + 17'(BEAT_BYTES - 1)) >> LOG_B);
    assign hdr_ok = bus.m_axi_rdata[95:48] == FEP && hdr_len >= 16'(MIN_PKT_LENGTH) &&
                    hdr_len <= 16'(MAX_PKT_LENGTH) && bus.m_axi_rresp == 2'b00;
    assign next_beat = (rd_ptr_q + BEAT_INC) & RING_MASK;
    assign keep_last = (tail_q == '0) ? '1 : ~({BEAT_BYTES{1'b1}} << tail_q);
    assign r_hs = bus.m_axi_rvalid & bus.m_axi_rready;

    // Burst length minus one: stop at the remaining beat count or the next 4 KB boundary
    function automatic logic [7:0] burst_len(input logic [ADDR_WIDTH-1:0] addr, input logic [15:0] rem);
        logic [12:0] to4k;
        to4k = (13'h1000 - {1'b0, addr[11:0]}) >> LOG_B;
        return 8'(((16'(to4k) < rem) ? 16'(to4k) : rem) - 16'd1);
    endfunction

    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = 3'(LOG_B);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = arvalid_q;
    // IDLE keeps rready high so stale beats left over from a reset are drained
    assign bus.m_axi_rready  = (state_q == IDLE || state_q == HDR_R) ? 1'b1 :
                               (state_q == BODY_R) ? bus.m_axis_tready : 1'b0;
    // Body beats pass straight through from R to the stream with no register stage
    assign bus.m_axis_tvalid = (state_q == HDR_OUT) | (state_q == BODY_R & bus.m_axi_rvalid);
    assign bus.m_axis_tdata  = (state_q == HDR_OUT) ? hdr_q : (state_q == BODY_R) ? bus.m_axi_rdata : '0;
    assign bus.m_axis_tlast  = bus.m_axis_tvalid & (rem_q == 16'd1);
    assign bus.m_axis_tkeep  = !bus.m_axis_tvalid ? '0 : (rem_q == 16'd1) ? keep_last : '1;
    assign ddr_rd_ptr = rd_ptr_q;
    assign pkt_cnt = pkt_q;
    assign err_cnt = err_q;

    // Packet FSM: header fetch and check, header emit, then 4 KB-split body bursts
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            araddr_q  <= '0;
            baddr_q   <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            hdr_q     <= '0;
            tail_q    <= '0;
            rem_q     <= '0;
            pkt_q     <= '0;
            err_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (rd_en && rd_ptr_q != ddr_wr_ptr) begin
                    araddr_q  <= rd_ptr_q;
                    arlen_q   <= '0;
                    arvalid_q <= 1'b1;
                    state_q   <= HDR_AR;
                end
                HDR_AR: if (bus.m_axi_arready) begin
                    arvalid_q <= 1'b0;
                    state_q   <= HDR_R;
                end
                HDR_R: if (bus.m_axi_rvalid) begin
                    if (hdr_ok) begin
                        hdr_q   <= bus.m_axi_rdata;
                        tail_q  <= hdr_len[LOG_B-1:0];
                        rem_q   <= hdr_beats;
                        state_q <= HDR_OUT;
                    end else begin
                        err_q    <= err_q + 32'd1;
                        rd_ptr_q <= next_beat;
                        state_q  <= IDLE;
                    end
                end
                HDR_OUT: if (bus.m_axis_tready) begin
                    if (rem_q == 16'd1) begin
                        pkt_q    <= pkt_q + 32'd1;
                        rd_ptr_q <= next_beat;
                        state_q  <= IDLE;
                    end else begin
                        araddr_q  <= next_beat;
                        arlen_q   <= burst_len(next_beat, rem_q - 16'd1);
                        arvalid_q <= 1'b1;
                        rem_q     <= rem_q - 16'd1;
                        state_q   <= BODY_AR;
                    end
                end
                BODY_AR: if (bus.m_axi_arready) begin
                    arvalid_q <= 1'b0;
                    baddr_q   <= (araddr_q + ADDR_WIDTH'({arlen_q, {LOG_B{1'b0}}}) + BEAT_INC) & RING_MASK;
                    state_q   <= BODY_R;
                end
                BODY_R: if (r_hs) begin
                    rem_q <= rem_q - 16'd1;
                    if (bus.m_axi_rresp != 2'b00) err_q <= err_q + 32'd1;
                    if (rem_q == 16'd1) begin
                        pkt_q    <= pkt_q + 32'd1;
                        rd_ptr_q <= baddr_q;
                        state_q  <= IDLE;
                    end else if (bus.m_axi_rlast) begin
                        araddr_q  <= baddr_q;
                        arlen_q   <= burst_len(baddr_q, rem_q - 16'd1);
                        arvalid_q <= 1'b1;
                        state_q   <= BODY_AR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_egress_ddr_reader.sv
// tb_egress_ddr_reader: directed DDR-ring packets against a small AXI slave and AXIS sink
module tb_egress_ddr_reader;
    localparam logic [47:0] FEP = 48'h1ead_feb5_ac0d;

    logic        clk, rst, rd_en;
    logic [30:0] ddr_wr_ptr, ddr_rd_ptr;
    logic [31:0] pkt_cnt, err_cnt;

    egress_ddr_reader_if #(.ADDR_WIDTH(31), .DATA_WIDTH(512)) bus ();

    egress_ddr_reader #(.RING_BYTES(64'h4000)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .ddr_wr_ptr(ddr_wr_ptr), .ddr_rd_ptr(ddr_rd_ptr),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [511:0] mem [int unsigned];
    int unsigned wp;
    logic [31:0] aa[$];
    logic [7:0]  al[$];
    int unsigned ba[$];
    int          bl[$];
    logic [63:0] od[$], okq[$];
    logic        ol[$];
    int unsigned cur_addr;
    int          cur_left, ar_wait, cyc;
    int unsigned bad_resp_addr;
    logic        toggle, held, ar_hs, r_hs;
    logic [30:0] held_addr;
    logic [7:0]  held_len;
    int          unstable, mirror_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rd_mem(input int unsigned a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    // AXI slave with one arready wait state per AR, plus AXIS sink and channel monitors
    initial begin
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata = '0;
        bus.m_axi_rresp = 2'b00;
        bus.m_axi_rlast = 1'b0;
        bus.m_axis_tready = 1'b1;
        cur_left = 0; cur_addr = 0; ar_wait = 0; cyc = 0; held = 1'b0;
        unstable = 0; mirror_err = 0;
        forever begin
            @(negedge clk);
            ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
            r_hs = bus.m_axi_rvalid && bus.m_axi_rready;
            if (bus.m_axi_arvalid && !bus.m_axi_arready) begin
                if (held && (bus.m_axi_araddr != held_addr || bus.m_axi_arlen != held_len)) unstable++;
                held = 1'b1; held_addr = bus.m_axi_araddr; held_len = bus.m_axi_arlen;
            end
            if (ar_hs) begin
                if (held && (bus.m_axi_araddr != held_addr || bus.m_axi_arlen != held_len)) unstable++;
                held = 1'b0;
                aa.push_back(32'(bus.m_axi_araddr));
                al.push_back(bus.m_axi_arlen);
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                od.push_back(bus.m_axis_tdata[63:0]);
                okq.push_back(bus.m_axis_tkeep);
                ol.push_back(bus.m_axis_tlast);
            end
            if (bus.m_axis_tvalid && bus.m_axi_rvalid && bus.m_axi_rready != bus.m_axis_tready) mirror_err++;
            @(posedge clk);
            #1;
            if (ar_hs) begin
                ba.push_back(32'(bus.m_axi_araddr));
                bl.push_back(int'(bus.m_axi_arlen) + 1);
            end
            if (r_hs) begin
                cur_addr += 64;
                cur_left--;
            end
            if (cur_left == 0 && ba.size() > 0) begin
                cur_addr = ba.pop_front();
                cur_left = bl.pop_front();
            end
            bus.m_axi_rvalid = cur_left != 0;
            bus.m_axi_rdata = rd_mem(cur_addr);
            bus.m_axi_rlast = cur_left == 1;
            bus.m_axi_rresp = (cur_left != 0 && cur_addr == bad_resp_addr) ? 2'b10 : 2'b00;
            ar_wait = (bus.m_axi_arvalid && !ar_hs) ? ar_wait + 1 : 0;
            bus.m_axi_arready = ar_wait >= 2;
            bus.m_axis_tready = toggle ? (cyc % 3 != 1) : 1'b1;
            cyc++;
        end
    end

    task automatic put_pkt(input int unsigned addr, input logic [15:0] l1, input logic [15:0] l2,
                           input logic [15:0] l3, input logic [47:0] fep, input int nb);
        mem[addr] = {416'b0, fep, l3, l2, l1};
        for (int i = 1; i < nb; i++) mem[addr + 64 * i] = {448'b0, 32'hDA7A_0000, 32'(addr + 64 * i)};
        wp = (addr + 64 * nb) & 32'h3FFF;
    endtask

    task automatic clear_q();
        aa.delete(); al.delete(); od.delete(); okq.delete(); ol.delete();
    endtask

    task automatic drain(input string tag);
        ddr_wr_ptr = 31'(wp);
        for (int i = 0; i < 4000 && 32'(ddr_rd_ptr) != wp; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1;
        check(tag, 64'(ddr_rd_ptr), 64'(wp));
    endtask

    task automatic fill_to(input int unsigned target);
        int b;
        while (wp != target) begin
            b = int'((target - wp) / 64);
            if (b > 24) b = 24;
            put_pkt(wp, 16'(b == 1 ? 59 : b * 64 - 40), 16'(b == 1 ? 59 : b * 64 - 40),
                    16'(b == 1 ? 59 : b * 64 - 40), FEP, b);
        end
        drain("fill_rd_ptr");
        clear_q();
    endtask

    task automatic check_ar(input string tag, input int i, input logic [31:0] addr, input logic [7:0] len);
        check(tag, (i < aa.size()) ? 64'({aa[i], al[i]}) : '1, 64'({addr, len}));
    endtask

    task automatic check_beats(input string tag, input int unsigned base, input int n,
                               input logic [63:0] hdr, input logic [63:0] kl);
        check({tag, "_nbeats"}, 64'(od.size()), 64'(n));
        for (int i = 0; i < n && i < od.size(); i++) begin
            check({tag, "_data"}, od[i], (i == 0) ? hdr : {32'hDA7A_0000, 32'(base + 64 * i)});
            check({tag, "_keep"}, okq[i], (i == n - 1) ? kl : 64'hFFFF_FFFF_FFFF_FFFF);
            check({tag, "_last"}, 64'(ol[i]), 64'(i == n - 1));
        end
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; ddr_wr_ptr = '0; wp = 0; toggle = 1'b0;
        bad_resp_addr = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_ptr", 64'(ddr_rd_ptr), 64'h0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'h0);
        check("rst_err_cnt", 64'(err_cnt), 64'h0);
        check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'h0);
        check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'h0);
        check("arsize", 64'(bus.m_axi_arsize), 64'h6);
        check("arburst", 64'(bus.m_axi_arburst), 64'h1);
        rst = 1'b0;
        rd_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("empty_no_ar", 64'(aa.size()), 64'h0);

        put_pkt(0, 16'd100, 16'd100, 16'd100, FEP, 2);
        drain("t1_rd_ptr");
        check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("t1_ar_n", 64'(aa.size()), 64'd2);
        check_ar("t1_ar_hdr", 0, 32'h0, 8'd0);
        check_ar("t1_ar_body", 1, 32'h40, 8'd0);
        check_beats("t1", 0, 2, 64'hac0d_0064_0064_0064, 64'h0000_000F_FFFF_FFFF);
        clear_q();

        put_pkt(32'h80, 16'd100, 16'd100, 16'd100, 48'h1ead_feb5_ac0e, 1);
        put_pkt(32'hC0, 16'd59, 16'd59, 16'd59, FEP, 1);
        drain("t2_rd_ptr");
        check("t2_err_cnt", 64'(err_cnt), 64'd1);
        check("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);
        check("t2_ar_n", 64'(aa.size()), 64'd2);
        check_ar("t2_ar_bad", 0, 32'h80, 8'd0);
        check_ar("t2_ar_good", 1, 32'hC0, 8'd0);
        check_beats("t2", 32'hC0, 1, 64'hac0d_003b_003b_003b, 64'h07FF_FFFF_FFFF_FFFF);
        clear_q();

        fill_to(32'hFC0);
        put_pkt(32'hFC0, 16'd1515, 16'd1515, 16'd1515, FEP, 24);
        drain("t3a_rd_ptr");
        check("t3a_ar_n", 64'(aa.size()), 64'd2);
        check_ar("t3a_ar_hdr", 0, 32'hFC0, 8'd0);
        check_ar("t3a_ar_body", 1, 32'h1000, 8'd22);
        check_beats("t3a", 32'hFC0, 24, 64'hac0d_05eb_05eb_05eb, 64'h0000_07FF_FFFF_FFFF);
        clear_q();

        fill_to(32'h1F80);
        put_pkt(32'h1F80, 16'd1515, 16'd1515, 16'd1515, FEP, 24);
        drain("t3b_rd_ptr");
        check("t3b_ar_n", 64'(aa.size()), 64'd3);
        check_ar("t3b_ar_hdr", 0, 32'h1F80, 8'd0);
        check_ar("t3b_ar_b0", 1, 32'h1FC0, 8'd0);
        check_ar("t3b_ar_b1", 2, 32'h2000, 8'd21);
        check_beats("t3b", 32'h1F80, 24, 64'hac0d_05eb_05eb_05eb, 64'h0000_07FF_FFFF_FFFF);
        clear_q();

        bad_resp_addr = 32'h25C0;
        put_pkt(32'h2580, 16'd612, 16'd100, 16'd100, FEP, 10);
`ifdef LEN_VOTE_EN
        wp = 32'h2600;
        drain("t4_rd_ptr");
        check_beats("t4", 32'h2580, 2, 64'hac0d_0064_0064_0264, 64'h0000_000F_FFFF_FFFF);
`else
        drain("t4_rd_ptr");
        check_beats("t4", 32'h2580, 10, 64'hac0d_0064_0064_0264, 64'h0000_000F_FFFF_FFFF);
`endif
        check("t4_err_cnt", 64'(err_cnt), 64'd2);
        bad_resp_addr = 32'hFFFF_FFFF;
        clear_q();

        fill_to(32'h3000);
        put_pkt(32'h3000, 16'd1515, 16'd1515, 16'd1515, FEP, 24);
        put_pkt(32'h3600, 16'd59, 16'd59, 16'd59, FEP, 1);
        toggle = 1'b1;
        ddr_wr_ptr = 31'(wp);
        for (int i = 0; i < 300 && od.size() == 0; i++) begin
            @(posedge clk);
            #1;
        end
        rd_en = 1'b0;
        for (int i = 0; i < 3000 && ddr_rd_ptr != 31'h3600; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (30) @(posedge clk);
        #1;
        check("t5_rd_ptr", 64'(ddr_rd_ptr), 64'h3600);
        check("t5_ar_n", 64'(aa.size()), 64'd2);
        check_ar("t5_ar_hdr", 0, 32'h3000, 8'd0);
        check_ar("t5_ar_body", 1, 32'h3040, 8'd22);
        check_beats("t5", 32'h3000, 24, 64'hac0d_05eb_05eb_05eb, 64'h0000_07FF_FFFF_FFFF);
        check("t5_rready_mirror", 64'(mirror_err), 64'd0);
        toggle = 1'b0;
        clear_q();
        rd_en = 1'b1;
        drain("t5b_rd_ptr");
        check_beats("t5b", 32'h3600, 1, 64'hac0d_003b_003b_003b, 64'h07FF_FFFF_FFFF_FFFF);
        clear_q();

        fill_to(32'h3FC0);
        put_pkt(32'h3FC0, 16'd64, 16'd64, 16'd64, FEP, 1);
        drain("t6_wrap_rd_ptr");
        check("t6_ar_n", 64'(aa.size()), 64'd1);
        check_ar("t6_ar_hdr", 0, 32'h3FC0, 8'd0);
        check_beats("t6", 32'h3FC0, 1, 64'hac0d_0040_0040_0040, 64'hFFFF_FFFF_FFFF_FFFF);
        clear_q();
        repeat (30) @(posedge clk);
        #1;
        check("t6_idle_no_ar", 64'(aa.size()), 64'd0);
        check("final_err_cnt", 64'(err_cnt), 64'd2);
        check("ar_stable", 64'(unstable), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
